envelope_capture: RTL and testbench

Receiving end of the homomorphic envelogram stream. The block accepts 16-bit envelope samples qualified by the pipeline's single-cycle write-enable strobe. It optionally decimates them and buffers them in a circular FIFO. The RISC-V core drains the FIFO through a simple request/valid read port and polls occupancy and error status.

---
 rtl/envelope_capture.sv | 99 +++++++++
 tb/tb_envelope_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/envelope_capture.sv
// Envelope sample capture: optional decimation into a circular FIFO drained by
// a request/valid read port, with occupancy and sticky overflow/underflow status.
module envelope_capture #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DECIM = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [15:0]                in_data,
  input  logic                       in_we,
  input  logic                       clr,
  input  logic                       rd_req,
  output logic [15:0]                rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  DC_LAST  = 8'(DECIM - 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count_q;
  logic [7:0]    dc;

  logic keep;
  logic rd_ok;
  logic wr_ok;
  logic is_full;
  logic is_empty;
  logic flush;

  always_comb begin
    flush    = RST || clr;
    is_full  = (count_q == FULL_CNT);
    is_empty = (count_q == '0);
    keep     = in_we && (dc == '0);
    rd_ok    = rd_req && !is_empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle;
    // an empty FIFO never bypasses, so a colliding read is rejected.
    wr_ok    = keep && (!is_full || rd_ok);
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge CLK) begin
    if (!flush && wr_ok) begin
      mem[wp] <= in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (flush) begin
      wp        <= '0;
      rp        <= '0;
      count_q   <= '0;
      dc        <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (in_we) begin
        dc <= (dc == DC_LAST) ? '0 : dc + 8'd1;
      end
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (keep && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (rd_ok) begin
        rd_data <= mem[rp];
        rp      <= rp + 1'b1;
      end
      if (rd_req && is_empty) begin
        underflow <= 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (rd_ok && !wr_ok) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  always_comb begin
    count = count_q;
    empty = is_empty;
    full  = is_full;
  end

endmodule

// File: tb/tb_envelope_capture.sv
// Directed self-checking bench: one FIFO without decimation, one with DECIM=4.
module tb_envelope_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [15:0] a_in_data, a_rd_data;
  logic        a_in_we, a_clr, a_rd_req, a_rd_valid, a_empty, a_full, a_ovf, a_unf;
  logic [6:0]  a_count;

  logic [15:0] b_in_data, b_rd_data;
  logic        b_in_we, b_clr, b_rd_req, b_rd_valid, b_empty, b_full, b_ovf, b_unf;
  logic [6:0]  b_count;

  envelope_capture #(.DEPTH(64), .DECIM(1)) dut_a (
    .CLK(clk), .RST(rst), .in_data(a_in_data), .in_we(a_in_we), .clr(a_clr),
    .rd_req(a_rd_req), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count),
    .empty(a_empty), .full(a_full), .overflow(a_ovf), .underflow(a_unf)
  );

  envelope_capture #(.DEPTH(64), .DECIM(4)) dut_b (
    .CLK(clk), .RST(rst), .in_data(b_in_data), .in_we(b_in_we), .clr(b_clr),
    .rd_req(b_rd_req), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .count(b_count),
    .empty(b_empty), .full(b_full), .overflow(b_ovf), .underflow(b_unf)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic we, input logic [15:0] d, input logic req);
    a_in_we = we; a_in_data = d; a_rd_req = req;
  endtask

  task automatic drive_b(input logic we, input logic [15:0] d, input logic req);
    b_in_we = we; b_in_data = d; b_rd_req = req;
  endtask

  initial begin
    rst = 1'b1;
    a_clr = 1'b0; b_clr = 1'b0;
    drive_a(1'b1, 16'h1234, 1'b0);
    drive_b(1'b1, 16'h1234, 1'b0);
    tick(); tick();
    check("rst_rd_data",  a_rd_data, 16'h0);
    check("rst_rd_valid", a_rd_valid, 1'b0);
    check("rst_count",    a_count, 7'd0);
    check("rst_empty",    a_empty, 1'b1);
    check("rst_full",     a_full, 1'b0);
    check("rst_ovf",      a_ovf, 1'b0);
    check("rst_unf",      a_unf, 1'b0);
    check("rst_b_count",  b_count, 7'd0);
    rst = 1'b0;
    drive_a(1'b0, 16'h0, 1'b0);
    drive_b(1'b0, 16'h0, 1'b0);
    tick();
    check("post_rst_count", a_count, 7'd0);
    check("post_rst_valid", a_rd_valid, 1'b0);

    // Order and latency
    for (int i = 1; i <= 5; i++) begin
      drive_a(1'b1, 16'(i), 1'b0);
      tick();
    end
    drive_a(1'b0, 16'h0, 1'b0);
    check("order_count", a_count, 7'd5);
    for (int i = 1; i <= 5; i++) begin
      drive_a(1'b0, 16'h0, 1'b1);
      tick();
      check("order_valid", a_rd_valid, 1'b1);
      check("order_data",  a_rd_data, 16'(i));
    end
    drive_a(1'b0, 16'h0, 1'b0);
    tick();
    check("order_valid_end", a_rd_valid, 1'b0);
    check("order_empty", a_empty, 1'b1);

    // Wrap, full and overflow
    for (int i = 0; i < 64; i++) begin
      drive_a(1'b1, 16'h0100 + 16'(i), 1'b0);
      tick();
    end
    check("fill_full",  a_full, 1'b1);
    check("fill_count", a_count, 7'd64);
    check("fill_ovf",   a_ovf, 1'b0);
    drive_a(1'b1, 16'h01FF, 1'b0);
    tick();
    check("ovf_set",   a_ovf, 1'b1);
    check("ovf_count", a_count, 7'd64);
    for (int i = 0; i < 64; i++) begin
      drive_a(1'b0, 16'h0, 1'b1);
      tick();
      check("wrap_data", a_rd_data, 16'h0100 + 16'(i));
    end
    drive_a(1'b0, 16'h0, 1'b0);
    tick();
    check("wrap_empty", a_empty, 1'b1);
    check("wrap_count", a_count, 7'd0);
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 16'h0200 + 16'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b0, 16'h0, 1'b1);
      tick();
      check("wrap3_valid", a_rd_valid, 1'b1);
      check("wrap3_data",  a_rd_data, 16'h0200 + 16'(i));
    end
    drive_a(1'b0, 16'h0, 1'b0);
    check("ovf_sticky", a_ovf, 1'b1);

    // clr, then full with simultaneous read and write
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("clr_a_ovf",   a_ovf, 1'b0);
    check("clr_a_count", a_count, 7'd0);
    for (int i = 0; i < 64; i++) begin
      drive_a(1'b1, 16'h0300 + 16'(i), 1'b0);
      tick();
    end
    check("rw_full_pre", a_full, 1'b1);
    drive_a(1'b1, 16'h03AA, 1'b1);
    tick();
    check("rw_ovf",   a_ovf, 1'b0);
    check("rw_count", a_count, 7'd64);
    check("rw_valid", a_rd_valid, 1'b1);
    check("rw_data",  a_rd_data, 16'h0300);
    for (int i = 1; i < 64; i++) begin
      drive_a(1'b0, 16'h0, 1'b1);
      tick();
      check("rw_drain", a_rd_data, 16'h0300 + 16'(i));
    end
    drive_a(1'b0, 16'h0, 1'b1);
    tick();
    check("rw_last", a_rd_data, 16'h03AA);
    check("rw_last_empty", a_empty, 1'b1);

    // Underflow and empty-cycle collision
    check("unf_pre", a_unf, 1'b0);
    drive_a(1'b0, 16'h0, 1'b1);
    tick();
    check("unf_set",   a_unf, 1'b1);
    check("unf_valid", a_rd_valid, 1'b0);
    check("unf_hold",  a_rd_data, 16'h03AA);
    drive_a(1'b1, 16'h00AA, 1'b1);
    tick();
    check("coll_unf",   a_unf, 1'b1);
    check("coll_count", a_count, 7'd1);
    check("coll_valid", a_rd_valid, 1'b0);
    drive_a(1'b0, 16'h0, 1'b1);
    tick();
    check("coll_pop_valid", a_rd_valid, 1'b1);
    check("coll_pop_data",  a_rd_data, 16'h00AA);
    drive_a(1'b0, 16'h0, 1'b0);

    // Decimation by 4 and clr priority
    for (int i = 0; i < 12; i++) begin
      drive_b(1'b1, 16'(i), 1'b0);
      tick();
    end
    drive_b(1'b0, 16'h0, 1'b0);
    check("dec_count", b_count, 7'd3);
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b0, 16'h0, 1'b1);
      tick();
      check("dec_data", b_rd_data, 16'(4 * i));
    end
    tick();
    check("dec_unf", b_unf, 1'b1);
    for (int i = 20; i < 25; i++) begin
      drive_b(1'b1, 16'(i), 1'b0);
      tick();
    end
    check("dec_count2", b_count, 7'd2);
    drive_b(1'b1, 16'd40, 1'b1);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    drive_b(1'b0, 16'h0, 1'b0);
    check("clr_count", b_count, 7'd0);
    check("clr_empty", b_empty, 1'b1);
    check("clr_unf",   b_unf, 1'b0);
    check("clr_ovf",   b_ovf, 1'b0);
    check("clr_valid", b_rd_valid, 1'b0);
    check("clr_data",  b_rd_data, 16'h0);
    drive_b(1'b1, 16'd50, 1'b0);
    tick();
    drive_b(1'b1, 16'd51, 1'b0);
    tick();
    drive_b(1'b0, 16'h0, 1'b1);
    check("post_clr_count", b_count, 7'd1);
    tick();
    drive_b(1'b0, 16'h0, 1'b0);
    check("post_clr_valid", b_rd_valid, 1'b1);
    check("post_clr_data",  b_rd_data, 16'd50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
